// File: rtl/mem_byte_sequencer.sv
// Load/store front-end that serialises 8/16/32-bit requests into single-byte memory beats.
// Optional macro MISALIGN_TRAP_EN: misaligned half/word requests return resp_err instead of accessing memory.
module mem_byte_sequencer #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic              memWrite,
   output logic              memRead,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_dataIn,
   input  logic [7:0]        mem_dataOut
);

   typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

   state_t            state;
   logic              write_q;
   logic              signed_q;
   logic [1:0]        last_q;   // index of final beat: 0, 1 or 3
   logic [1:0]        cnt;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] acc;
   logic [DATA_W-1:0] acc_nx;
   logic [1:0]        cnt_nx;
   logic [1:0]        req_last;

   function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] a,
                                                input logic [1:0] last,
                                                input logic sg);
      case (last)
         2'd0:    extend = sg ? {{24{a[7]}}, a[7:0]}   : {24'h0, a[7:0]};
         2'd1:    extend = sg ? {{16{a[15]}}, a[15:0]} : {16'h0, a[15:0]};
         default: extend = a;
      endcase
   endfunction

   always_comb begin
      acc_nx = acc;
      acc_nx[{cnt, 3'b000} +: 8] = mem_dataOut;
      cnt_nx = cnt + 2'd1;
      case (req_size)
         2'b00:   req_last = 2'd0;
         2'b01:   req_last = 2'd1;
         default: req_last = 2'd3;
      endcase
   end

`ifdef MISALIGN_TRAP_EN
   logic misalign;
   assign misalign = (req_size == 2'b01 && req_addr[0]) ||
                     (req_size[1] && req_addr[1:0] != 2'b00);
`else
   assign resp_err = 1'b0;
`endif

   assign req_ready = (state == IDLE);

   // Memory-side outputs are registered so they settle well before the memory's negedge write.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         cnt        <= 2'd0;
         write_q    <= 1'b0;
         signed_q   <= 1'b0;
         last_q     <= 2'd0;
         addr_q     <= '0;
         wdata_q    <= '0;
         acc        <= '0;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         memWrite   <= 1'b0;
         memRead    <= 1'b0;
         mem_addr   <= '0;
         mem_dataIn <= 8'h00;
`ifdef MISALIGN_TRAP_EN
         resp_err   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               write_q  <= req_write;
               signed_q <= req_signed;
               last_q   <= req_last;
               addr_q   <= req_addr;
               wdata_q  <= req_wdata;
               acc      <= '0;
               cnt      <= 2'd0;
`ifdef MISALIGN_TRAP_EN
               if (misalign) begin
                  state      <= RESP;
                  resp_valid <= 1'b1;
                  resp_rdata <= '0;
                  resp_err   <= 1'b1;
               end else
`endif
               begin
                  state      <= XFER;
                  memWrite   <= req_write;
                  memRead    <= ~req_write;
                  mem_addr   <= req_addr;
                  mem_dataIn <= req_wdata[7:0];
               end
            end
            XFER: begin
               if (!write_q) acc <= acc_nx;
               if (cnt == last_q) begin
                  state      <= RESP;
                  memWrite   <= 1'b0;
                  memRead    <= 1'b0;
                  resp_valid <= 1'b1;
                  resp_rdata <= write_q ? '0 : extend(acc_nx, last_q, signed_q);
               end else begin
                  cnt        <= cnt_nx;
                  // low nibble wraps; upper address bits never see a carry
                  mem_addr   <= {addr_q[ADDR_W-1:4], addr_q[3:0] + {2'b00, cnt_nx}};
                  mem_dataIn <= wdata_q[{cnt_nx, 3'b000} +: 8];
               end
            end
            RESP: if (resp_ready) begin
               state      <= IDLE;
               resp_valid <= 1'b0;
               resp_rdata <= '0;
`ifdef MISALIGN_TRAP_EN
               resp_err   <= 1'b0;
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_byte_sequencer.sv
// Bench for mem_byte_sequencer with a 16x8 byte memory model (reset contents byte k = k+1).
module tb_mem_byte_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_write, req_signed;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_ready, resp_err;
   logic [31:0] resp_rdata;
   logic        memWrite, memRead;
   logic [31:0] mem_addr;
   logic [7:0]  mem_dataIn, mem_dataOut;

   always #5 clk = ~clk;

   mem_byte_sequencer dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err), .memWrite(memWrite),
      .memRead(memRead), .mem_addr(mem_addr), .mem_dataIn(mem_dataIn),
      .mem_dataOut(mem_dataOut)
   );

   logic [7:0] mem [16];
   logic       mem_rst;

   always @(negedge clk) begin
      if (mem_rst) begin
         for (int k = 0; k < 16; k++) mem[k] <= 8'(k + 1);
      end else if (memWrite) begin
         mem[mem_addr[3:0]] <= mem_dataIn;
      end
   end
   assign mem_dataOut = mem[mem_addr[3:0]];

   int          rd_cnt = 0, wr_cnt = 0;
   logic [31:0] wr_log[$];
   logic [31:0] rd_log[$];
   always @(negedge clk) begin
      if (memRead)  begin rd_cnt++; rd_log.push_back(mem_addr); end
      if (memWrite) begin wr_cnt++; wr_log.push_back(mem_addr); end
   end

   typedef struct packed {logic [31:0] rdata; logic err;} exp_t;
   exp_t sb[$];

   int pass_cnt = 0, total = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic send(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] er, input logic ee);
      int n = 0;
      exp_t e;
      e.rdata = er; e.err = ee;
      sb.push_back(e);
      @(negedge clk);
      req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
      req_valid = 1'b1;
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
      chk("accept", 32'(n < 20), 32'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   task automatic get_resp(input string tag, input int exp_lat);
      int   lat = 0;
      exp_t e;
      while (lat < 20) begin
         @(negedge clk);
         lat++;
         if (resp_valid) break;
      end
      chk({tag, "_valid"}, 32'(resp_valid), 32'd1);
      if (exp_lat > 0) chk({tag, "_lat"}, lat, exp_lat);
      chk({tag, "_sb"}, 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk({tag, "_rdata"}, resp_rdata, e.rdata);
         chk({tag, "_err"}, 32'(resp_err), 32'(e.err));
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int r0, w0, b, seen;
      reset = 1'b0; mem_rst = 1'b1; resp_ready = 1'b1;
      req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
      req_addr = '0; req_wdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);
      chk("rst_resp_err", 32'(resp_err), 32'd0);
      chk("rst_mem_we_re", {30'd0, memWrite, memRead}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_din", 32'(mem_dataIn), 32'd0);
      mem_rst = 1'b0;
      reset   = 1'b1;

      // word load from 0
      r0 = rd_cnt;
      send(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h04030201, 1'b0);
      get_resp("ld_w0", 5);
      chk("ld_w0_rd_cycles", rd_cnt - r0, 4);

      // word store then readback
      w0 = wr_cnt; b = wr_log.size();
      send(1'b1, 2'b10, 1'b0, 32'h4, 32'hDEADBEEF, 32'h0, 1'b0);
      get_resp("st_w4", 5);
      chk("st_w4_wr_cycles", wr_cnt - w0, 4);
      for (int i = 0; i < 4; i++)
         if (b + i < wr_log.size()) chk($sformatf("st_w4_addr%0d", i), wr_log[b + i], 32'(4 + i));
      send(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'hDEADBEEF, 1'b0);
      get_resp("ld_w4", 5);

      // byte store, signed/unsigned byte loads
      send(1'b1, 2'b00, 1'b0, 32'h9, 32'h1234_5680, 32'h0, 1'b0);
      get_resp("st_b9", 2);
      send(1'b0, 2'b00, 1'b1, 32'h9, 32'h0, 32'hFFFFFF80, 1'b0);
      get_resp("ld_b9s", 2);
      send(1'b0, 2'b00, 1'b0, 32'h9, 32'h0, 32'h00000080, 1'b0);
      get_resp("ld_b9u", 2);

      // half store, signed and unsigned half loads
      send(1'b1, 2'b01, 1'b0, 32'h2, 32'hFFFF_8001, 32'h0, 1'b0);
      get_resp("st_h2", 3);
      send(1'b0, 2'b01, 1'b1, 32'h2, 32'h0, 32'hFFFF8001, 1'b0);
      get_resp("ld_h2s", 3);
      send(1'b0, 2'b01, 1'b0, 32'hC, 32'h0, 32'h00000E0D, 1'b0);
      get_resp("ld_hCu", 3);

      // misaligned word load across the nibble boundary
      r0 = rd_cnt; b = rd_log.size();
`ifdef MISALIGN_TRAP_EN
      send(1'b0, 2'b10, 1'b0, 32'h1230_000E, 32'h0, 32'h0, 1'b1);
      get_resp("ld_wE_trap", 1);
      chk("ld_wE_trap_rd_cycles", rd_cnt - r0, 0);
`else
      send(1'b0, 2'b11, 1'b0, 32'h1230_000E, 32'h0, 32'h0201100F, 1'b0);
      get_resp("ld_wE", 5);
      chk("ld_wE_rd_cycles", rd_cnt - r0, 4);
      if (b + 3 < rd_log.size()) begin
         chk("ld_wE_addr0", rd_log[b],     32'h1230_000E);
         chk("ld_wE_addr1", rd_log[b + 1], 32'h1230_000F);
         chk("ld_wE_addr2", rd_log[b + 2], 32'h1230_0000);
         chk("ld_wE_addr3", rd_log[b + 3], 32'h1230_0001);
      end
`endif

      // response back-pressure with a competing request
      resp_ready = 1'b0;
      send(1'b0, 2'b00, 1'b0, 32'h9, 32'h0, 32'h00000080, 1'b0);
      seen = 0;
      while (seen < 20 && !resp_valid) begin @(negedge clk); seen++; end
      req_write = 1'b1; req_size = 2'b00; req_addr = 32'h0; req_wdata = 32'h55;
      req_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("hold%0d_valid", i), 32'(resp_valid), 32'd1);
         chk($sformatf("hold%0d_rdata", i), resp_rdata, 32'h00000080);
         chk($sformatf("hold%0d_req_ready", i), 32'(req_ready), 32'd0);
      end
      if (sb.size() != 0) void'(sb.pop_front());
      resp_ready = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      w0 = wr_cnt;
      repeat (6) @(negedge clk);
      chk("hold_ignored_writes", wr_cnt - w0, 0);
      chk("hold_no_resp", 32'(resp_valid), 32'd0);
      chk("hold_mem0", 32'(mem[0]), 32'h01);

      // reset during the second beat of a word store to 0
      @(negedge clk);
      req_write = 1'b1; req_size = 2'b10; req_signed = 1'b0;
      req_addr = 32'h0; req_wdata = 32'hAABBCCDD; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;
      seen = 0;
      w0 = wr_cnt;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (resp_valid || !req_ready) seen++;
      end
      chk("abort_idle_no_resp", seen, 0);
      chk("abort_no_writes", wr_cnt - w0, 0);
      chk("abort_mem0", 32'(mem[0]), 32'hDD);
      chk("abort_mem1", 32'(mem[1]), 32'hCC);
      chk("abort_mem2", 32'(mem[2]), 32'h01);
      chk("abort_mem3", 32'(mem[3]), 32'h80);
      send(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h8001CCDD, 1'b0);
      get_resp("ld_w0_after_abort", 5);

      chk("sb_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
